led_sprite_blitter: RTL and testbench

Pixel-pipeline stage that feeds the 32×32 RGB565 LED sprite ROMs (`rom_led_off`, and its lit counterpart) and consumes their output. It sits between the VGA timing generator and the video output mux. For each pixel it computes the sprite-relative ROM address and selects the on or off image according to an LED mode with optional frame-based blinking. It then overlays the sprite onto a background colour, treating 0x0000 as transparent.

---
 rtl/led_sprite_blitter.sv | 114 +++++++++++
 tb/tb_led_sprite_blitter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/led_sprite_blitter.sv
// LED sprite blitter: maps screen x/y to sprite ROM addresses, picks the lit or unlit
// image (with frame-locked blinking), and composites opaque texels over the background.
module led_sprite_blitter #(
  parameter int SPRITE_X     = 100,
  parameter int SPRITE_Y     = 50,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        de,
  input  logic        frame_start,
  input  logic [15:0] bg_rgb,
  input  logic [1:0]  led_mode,
  output logic [9:0]  rom_ad,
  input  logic [15:0] rom_on_dout,
  input  logic [15:0] rom_off_dout,
  output logic [15:0] pix_rgb,
  output logic        pix_de,
  output logic        pix_hit
);

  localparam logic [10:0] SIZE = 11'(32 << SCALE_LOG2);
  localparam int          CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        hit0;

  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          show_on_q, show_on_d;

  logic        hit1_q, de1_q;
  logic [15:0] bg1_q;

  logic [15:0] texel;
  logic        pix_hit_d, pix_de_d;
  logic [15:0] pix_rgb_d;
  logic [15:0] pix_rgb_q;
  logic        pix_hit_q, pix_de_q;

  // Borrow bit (bit 10) flags pixels left of / above the sprite origin.
  always_comb begin
    dx     = {1'b0, x} - 11'(SPRITE_X);
    dy     = {1'b0, y} - 11'(SPRITE_Y);
    hit0   = de & ~dx[10] & ~dy[10] & (dx < SIZE) & (dy < SIZE);
    rom_ad = {dy[SCALE_LOG2+4:SCALE_LOG2], dx[SCALE_LOG2+4:SCALE_LOG2]};
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    show_on_d     = show_on_q;
    if (frame_start) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      // Mode is latched only at frame start so a frame never tears.
      case (led_mode)
        2'b01:   show_on_d = 1'b1;
        2'b10:   show_on_d = blink_phase_d;
        default: show_on_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    texel     = show_on_q ? rom_on_dout : rom_off_dout;
    pix_hit_d = hit1_q & (texel != 16'h0000);
    pix_de_d  = de1_q;
    if (!de1_q)
      pix_rgb_d = 16'h0000;
    else if (pix_hit_d)
      pix_rgb_d = texel;
    else
      pix_rgb_d = bg1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      show_on_q     <= 1'b0;
      hit1_q        <= 1'b0;
      de1_q         <= 1'b0;
      bg1_q         <= 16'h0000;
      pix_rgb_q     <= 16'h0000;
      pix_hit_q     <= 1'b0;
      pix_de_q      <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      show_on_q     <= show_on_d;
      hit1_q        <= hit0;
      de1_q         <= de;
      bg1_q         <= bg_rgb;
      pix_rgb_q     <= pix_rgb_d;
      pix_hit_q     <= pix_hit_d;
      pix_de_q      <= pix_de_d;
    end
  end

  assign pix_rgb = pix_rgb_q;
  assign pix_hit = pix_hit_q;
  assign pix_de  = pix_de_q;

endmodule

// File: tb/tb_led_sprite_blitter.sv
// Directed bench for led_sprite_blitter: unscaled and 2x-scaled instances share stimulus.
`timescale 1ns/1ps
module tb_led_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        de, frame_start;
  logic [15:0] bg_rgb;
  logic [1:0]  led_mode;
  logic [15:0] rom_on_dout, rom_off_dout;

  logic [9:0]  rom_ad, rom_ad_s;
  logic [15:0] pix_rgb, pix_rgb_s;
  logic        pix_de, pix_de_s, pix_hit, pix_hit_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_sprite_blitter #(.SCALE_LOG2(0), .BLINK_FRAMES(3)) u_dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .de(de), .frame_start(frame_start),
    .bg_rgb(bg_rgb), .led_mode(led_mode), .rom_ad(rom_ad),
    .rom_on_dout(rom_on_dout), .rom_off_dout(rom_off_dout),
    .pix_rgb(pix_rgb), .pix_de(pix_de), .pix_hit(pix_hit));

  led_sprite_blitter #(.SCALE_LOG2(1), .BLINK_FRAMES(3)) u_dut_s (
    .clk(clk), .reset(reset), .x(x), .y(y), .de(de), .frame_start(frame_start),
    .bg_rgb(bg_rgb), .led_mode(led_mode), .rom_ad(rom_ad_s),
    .rom_on_dout(rom_on_dout), .rom_off_dout(rom_off_dout),
    .pix_rgb(pix_rgb_s), .pix_de(pix_de_s), .pix_hit(pix_hit_s));

  typedef struct {
    logic [9:0]  x, y;
    logic        de;
    logic [15:0] bg, on;
    logic        cad0;
    logic [9:0]  ad0;
    logic        hit0;
    logic [15:0] rgb0;
    logic        cads;
    logic [9:0]  ads;
    logic        hits;
    logic [15:0] rgbs;
    logic        pde;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    de = 1'b0; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One inside pixel, ROM data on the following cycle, outputs checked two edges later.
  task automatic probe(input string name, input logic [15:0] exp_rgb);
    @(negedge clk);
    x = 10'd105; y = 10'd55; de = 1'b1; bg_rgb = 16'h00FF;
    @(negedge clk);
    de = 1'b0; rom_on_dout = 16'hAAAA; rom_off_dout = 16'h5555;
    @(negedge clk);
    chk(name, pix_rgb, exp_rgb);
    $display("[TB] probe %s rgb=%h", name, pix_rgb);
  endtask

  initial begin
    //           x    y    de bg       on       cad0 ad0    h0 rgb0     cads ads    hs rgbs     pde
    vecs[0]  = '{100, 50,  1, 16'h001F, 16'hA534, 1, 10'h000, 1, 16'hA534, 1, 10'h000, 1, 16'hA534, 1};
    vecs[1]  = '{131, 81,  1, 16'h001F, 16'hA534, 1, 10'h3FF, 1, 16'hA534, 1, 10'h1EF, 1, 16'hA534, 1};
    vecs[2]  = '{132, 81,  1, 16'h001F, 16'hA534, 0, 10'h000, 0, 16'h001F, 1, 10'h1F0, 1, 16'hA534, 1};
    vecs[3]  = '{102, 53,  1, 16'h07E0, 16'hA534, 1, 10'h062, 1, 16'hA534, 1, 10'h021, 1, 16'hA534, 1};
    vecs[4]  = '{163, 53,  1, 16'h07E0, 16'h1357, 0, 10'h000, 0, 16'h07E0, 1, 10'h03F, 1, 16'h1357, 1};
    vecs[5]  = '{164, 53,  1, 16'hF800, 16'h1357, 0, 10'h000, 0, 16'hF800, 0, 10'h000, 0, 16'hF800, 1};
    vecs[6]  = '{99,  60,  1, 16'hF800, 16'h1357, 0, 10'h000, 0, 16'hF800, 0, 10'h000, 0, 16'hF800, 1};
    vecs[7]  = '{100, 49,  1, 16'h001F, 16'h1357, 0, 10'h000, 0, 16'h001F, 0, 10'h000, 0, 16'h001F, 1};
    vecs[8]  = '{110, 60,  0, 16'h001F, 16'hA534, 0, 10'h000, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 0};
    vecs[9]  = '{110, 60,  1, 16'h001F, 16'h0000, 1, 10'h14A, 0, 16'h001F, 1, 10'h0A5, 0, 16'h001F, 1};
    vecs[10] = '{0,   0,   1, 16'h0F0F, 16'hA534, 0, 10'h000, 0, 16'h0F0F, 0, 10'h000, 0, 16'h0F0F, 1};
    vecs[11] = '{1023,1023,1, 16'h0F0F, 16'hA534, 0, 10'h000, 0, 16'h0F0F, 0, 10'h000, 0, 16'h0F0F, 1};

    reset = 1'b1; x = '0; y = '0; de = 1'b0; frame_start = 1'b0;
    bg_rgb = '0; led_mode = 2'b00; rom_on_dout = 16'hFFFF; rom_off_dout = 16'hFFFF;
    repeat (2) @(negedge clk);
    de = 1'b1; x = 10'd105; y = 10'd55; bg_rgb = 16'h1234;
    repeat (2) @(negedge clk);
    chk("reset_rgb", pix_rgb, 16'h0000);
    chk("reset_de", {15'd0, pix_de}, 16'd0);
    chk("reset_hit", {15'd0, pix_hit}, 16'd0);
    $display("[TB] reset rgb=%h de=%b hit=%b", pix_rgb, pix_de, pix_hit);
    de = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    led_mode = 2'b01;
    pulse_frame();

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      x = vecs[i].x; y = vecs[i].y; de = vecs[i].de; bg_rgb = vecs[i].bg;
      #1;
      if (vecs[i].cad0) chk($sformatf("v%0d_ad0", i), {6'd0, rom_ad}, {6'd0, vecs[i].ad0});
      if (vecs[i].cads) chk($sformatf("v%0d_ads", i), {6'd0, rom_ad_s}, {6'd0, vecs[i].ads});
      @(negedge clk);
      de = 1'b0; rom_on_dout = vecs[i].on; rom_off_dout = 16'h1234;
      @(negedge clk);
      chk($sformatf("v%0d_rgb0", i), pix_rgb, vecs[i].rgb0);
      chk($sformatf("v%0d_hit0", i), {15'd0, pix_hit}, {15'd0, vecs[i].hit0});
      chk($sformatf("v%0d_de0", i), {15'd0, pix_de}, {15'd0, vecs[i].pde});
      chk($sformatf("v%0d_rgbs", i), pix_rgb_s, vecs[i].rgbs);
      chk($sformatf("v%0d_hits", i), {15'd0, pix_hit_s}, {15'd0, vecs[i].hits});
      $display("[TB] vec %0d x=%0d y=%0d ad=%h ads=%h rgb=%h rgbs=%h", i, vecs[i].x, vecs[i].y,
               rom_ad, rom_ad_s, pix_rgb, pix_rgb_s);
    end

    // Back-to-back pixels: transparent texel then opaque, one clock apart.
    @(negedge clk);
    x = 10'd100; y = 10'd50; de = 1'b1; bg_rgb = 16'h001F;
    @(negedge clk);
    x = 10'd101; rom_on_dout = 16'h0000;
    @(negedge clk);
    de = 1'b0; rom_on_dout = 16'hA534;
    chk("lat_n2_rgb", pix_rgb, 16'h001F);
    chk("lat_n2_hit", {15'd0, pix_hit}, 16'd0);
    @(negedge clk);
    chk("lat_n3_rgb", pix_rgb, 16'hA534);
    chk("lat_n3_hit", {15'd0, pix_hit}, 16'd1);
    $display("[TB] latency pair rgb=%h hit=%b", pix_rgb, pix_hit);

    // Mode change mid-frame waits for the next frame start.
    probe("mode_on", 16'hAAAA);
    led_mode = 2'b00;
    probe("mode_mid", 16'hAAAA);
    pulse_frame();
    probe("mode_off", 16'h5555);

    // Asynchronous reset between edges while a pixel is being shown.
    led_mode = 2'b01;
    pulse_frame();
    @(negedge clk);
    x = 10'd105; y = 10'd55; de = 1'b1; bg_rgb = 16'h00FF;
    @(negedge clk);
    rom_on_dout = 16'hAAAA; rom_off_dout = 16'h5555;
    @(posedge clk);
    #1;
    chk("pre_rst_rgb", pix_rgb, 16'hAAAA);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rgb", pix_rgb, 16'h0000);
    chk("async_de", {15'd0, pix_de}, 16'd0);
    chk("async_hit", {15'd0, pix_hit}, 16'd0);
    $display("[TB] async reset rgb=%h de=%b hit=%b", pix_rgb, pix_de, pix_hit);
    @(negedge clk);
    reset = 1'b0; de = 1'b0;
    probe("post_rst_off", 16'h5555);
    pulse_frame();
    probe("post_rst_on", 16'hAAAA);

    // Blink with a 3-frame half period.
    do_reset();
    led_mode = 2'b10;
    begin
      logic [15:0] blink_exp [7];
      blink_exp = '{16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555};
      for (int k = 0; k < 7; k++) begin
        pulse_frame();
        probe($sformatf("blink%0d", k), blink_exp[k]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
